bus_par_rx: RTL and testbench



---
 rtl/bus_par_rx.sv | 127 ++++++++++++
 tb/tb_bus_par_rx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_par_rx.sv
// bus_par_rx: tristate bus reader with parity check, FIFO, error counter.
// Define BUS_PAR_ODD_EN for odd parity; even parity by default.
module bus_par_rx #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       bus_d,
  input  logic             bus_p,
  input  logic             bus_stb,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             par_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic             ovf,
  input  logic             clr
);

`ifdef BUS_PAR_ODD_EN
  localparam logic PAR_SENSE = 1'b1;
`else
  localparam logic PAR_SENSE = 1'b0;
`endif

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {
    IDLE,
    CHECK
  } state_t;

  state_t state_q, state_d;

  logic [7:0]    cap_d;
  logic          cap_p;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  logic chk, pass, good, bad;
  logic full, push, pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus_stb)  state_d = CHECK;
      CHECK:   if (!bus_stb) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sampled every strobe cycle so back-to-back strobes stream through
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_d <= '0;
      cap_p <= 1'b0;
    end else if (bus_stb) begin
      cap_d <= bus_d;
      cap_p <= bus_p;
    end
  end

  assign chk  = (state_q == CHECK);
  assign pass = ((^cap_d) ^ cap_p) == PAR_SENSE;
  assign good = chk & pass;
  assign bad  = chk & ~pass;

  assign full = (count == FULL_CNT);
  assign pop  = rd_valid & rd_ready;
  // A pop in the same cycle frees the slot for a full FIFO
  assign push = good & (~full | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
    end else if (push) begin
      mem[wr_ptr] <= cap_d;
      wr_ptr      <= wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   rd_ptr <= '0;
    else if (pop) rd_ptr <= rd_ptr + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
      ovf     <= 1'b0;
    end else if (clr) begin
      err_cnt <= '0;
      ovf     <= 1'b0;
    end else begin
      if (bad && (err_cnt != '1))
        err_cnt <= err_cnt + 1'b1;
      if (good && full && !pop)
        ovf <= 1'b1;
    end
  end

  assign rd_data  = mem[rd_ptr];
  assign rd_valid = (count != '0);
  assign par_err  = bad;

endmodule

// File: tb/tb_bus_par_rx.sv
// tb_bus_par_rx: scoreboard bench for bus_par_rx.
// Expected read bytes are queued by stimulus and checked by a monitor.
module tb_bus_par_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] bus_d = '0;
  logic       bus_p = 1'b0;
  logic       bus_stb = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic       par_err;
  logic [7:0] err_cnt;
  logic       ovf;
  logic       clr = 1'b0;

  int checks = 0;
  int errors = 0;
  int pe_seen = 0;
  logic [7:0] exp_q [$];

  bus_par_rx #(.DEPTH(4), .AW(2), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus_d    (bus_d),
    .bus_p    (bus_p),
    .bus_stb  (bus_stb),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .par_err  (par_err),
    .err_cnt  (err_cnt),
    .ovf      (ovf),
    .clr      (clr)
  );

  always #5 clk = ~clk;

  function automatic logic gpar(input logic [7:0] d);
`ifdef BUS_PAR_ODD_EN
    return ~(^d);
`else
    return ^d;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               name, act, act, req, req);
    end
  endtask

  // Monitor: pops happen on the following posedge when valid & ready
  always @(negedge clk) begin
    if (rst_n) begin
      if (par_err) pe_seen++;
      if (rd_valid && rd_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected: got 0x%0h expected none", rd_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (rd_data !== e) begin
            errors++;
            $display("FAIL rd_data: got 0x%0h expected 0x%0h", rd_data, e);
          end
        end
      end
    end
  end

  // Called at posedge+1; leaves at the next posedge+1
  task automatic strobe(input logic [7:0] d, input logic p,
                        input logic accept);
    bus_d   = d;
    bus_p   = p;
    bus_stb = 1'b1;
    if (accept) exp_q.push_back(d);
    @(posedge clk); #1;
    bus_stb = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    rd_ready = 1'b1;
    while ((exp_q.size() != 0 || rd_valid) && t < 50) begin
      step(1);
      t++;
    end
    rd_ready = 1'b0;
    chk({name, "_timeout"}, int'(t >= 50), 0);
  endtask

  initial begin
    int pe0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    // reset state
    chk("rst_valid", rd_valid, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_par_err", par_err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_ovf", ovf, 0);

    // single good byte, latency two edges
    strobe(8'hA5, gpar(8'hA5), 1'b1);
    chk("lat1_valid", rd_valid, 0);
    step(1);
    chk("lat2_valid", rd_valid, 1);
    chk("lat2_data", rd_data, 8'hA5);
    drain("single");
    chk("single_pe", pe_seen, 0);
    chk("single_err", err_cnt, 0);

    // single bad byte
    strobe(8'h01, ~gpar(8'h01), 1'b0);
    @(negedge clk);
    chk("bad_pe_on", par_err, 1);
    step(1);
    @(negedge clk);
    chk("bad_pe_off", par_err, 0);
    chk("bad_cnt", err_cnt, 1);
    chk("bad_valid", rd_valid, 0);
    chk("bad_pe_seen", pe_seen, 1);
    step(1);

    // saturation after 300 bad bytes
    for (int i = 0; i < 299; i++)
      strobe(8'h01, ~gpar(8'h01), 1'b0);
    step(2);
    chk("sat_cnt", err_cnt, 255);
    chk("sat_pe_seen", pe_seen, 300);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("clr_cnt", err_cnt, 0);

    // back-to-back fill, then overflow
    for (int i = 0; i < 4; i++)
      strobe(8'h10 + 8'(i), gpar(8'h10 + 8'(i)), 1'b1);
    step(1);
    chk("fill_valid", rd_valid, 1);
    chk("fill_head", rd_data, 8'h10);
    chk("fill_ovf", ovf, 0);
    strobe(8'hFF, gpar(8'hFF), 1'b0);
    step(1);
    chk("ovf_set", ovf, 1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("ovf_clr", ovf, 0);
    chk("ovf_clr_cnt", err_cnt, 0);
    drain("b2b");
    chk("b2b_empty", rd_valid, 0);
    chk("b2b_ovf", ovf, 0);

    // full with simultaneous push and pop
    for (int i = 0; i < 4; i++)
      strobe(8'h20 + 8'(i), gpar(8'h20 + 8'(i)), 1'b1);
    strobe(8'h24, gpar(8'h24), 1'b1);
    rd_ready = 1'b1;
    step(1);
    rd_ready = 1'b0;
    step(1);
    chk("pp_ovf", ovf, 0);
    chk("pp_valid", rd_valid, 1);
    chk("pp_head", rd_data, 8'h21);
    drain("pp");
    chk("pp_ovf2", ovf, 0);

    // async reset during CHECK of a bad byte
    pe0 = pe_seen;
    step(1);
    strobe(8'h01, ~gpar(8'h01), 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", rd_valid, 0);
    chk("arst_pe", par_err, 0);
    chk("arst_cnt", err_cnt, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_data", rd_data, 0);
    @(posedge clk); #4 rst_n = 1'b1;
    step(3);
    chk("arst_pe_seen", pe_seen - pe0, 0);
    chk("arst_valid2", rd_valid, 0);
    chk("arst_cnt2", err_cnt, 0);

    // FIFO still works after reset
    strobe(8'h5A, gpar(8'h5A), 1'b1);
    step(1);
    drain("post");
    chk("end_q", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

endmodule
